// File: rtl/frame_streamer_if.sv
// Memory read port and pixel stream toward the convolver's shift register.
// The streamer side uses the master modport; memory and consumer sit on slave.
interface frame_streamer_if #(
    parameter int data_width = 32,
    parameter int addr_width = 16
);
    logic                  mem_rd_en;
    logic [addr_width-1:0] mem_addr;
    logic [data_width-1:0] mem_rd_data;
    logic [data_width-1:0] shift_in;
    logic                  shift_valid;
    logic                  shift_ready;
    logic                  three_shift;

    modport master (
        output mem_rd_en, mem_addr, shift_in, shift_valid, three_shift,
        input  mem_rd_data, shift_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, shift_in, shift_valid, three_shift,
        output mem_rd_data, shift_ready
    );
endinterface

// File: rtl/frame_streamer.sv
// Reads an img_width x img_height frame row-major from 1-cycle-latency memory
// and streams it through a 2-entry prefetch buffer, flagging column 0 of each row.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing reads and streaming pixels
//   DONE  | single cycle, frame_done pulse
module frame_streamer #(
    parameter int data_width = 32,
    parameter int addr_width = 16,
    parameter int img_width  = 8,
    parameter int img_height = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    frame_streamer_if.master      bus,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int n_pix = img_width * img_height;
    localparam int cnt_w = $clog2(n_pix + 1);
    localparam int col_w = $clog2(img_width + 1);
    localparam logic [cnt_w-1:0] n_pix_c  = cnt_w'(n_pix);
    localparam logic [cnt_w-1:0] last_pix = cnt_w'(n_pix - 1);
    localparam logic [col_w-1:0] last_col = col_w'(img_width - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [addr_width-1:0] base;
    logic [cnt_w-1:0]      rd_idx;
    logic [cnt_w-1:0]      pix_cnt;
    logic [col_w-1:0]      head_col;
    logic                  inflight;
    logic [data_width-1:0] buf_q [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    assign bus.shift_valid = (count != 2'd0);
    assign bus.shift_in    = buf_q[rd_ptr];
    assign bus.three_shift = bus.shift_valid && (head_col == '0);

    // Occupancy counts the read already in flight so the buffer can never overflow.
    assign pop           = bus.shift_valid && bus.shift_ready;
    assign occ           = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue         = (state == RUN) && (rd_idx < n_pix_c) && (occ < 3'd2);
    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = base + addr_width'(rd_idx);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            rd_idx     <= '0;
            pix_cnt    <= '0;
            head_col   <= '0;
            inflight   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            inflight   <= issue;
            count      <= count + 2'(inflight) - 2'(pop);
            if (issue) begin
                rd_idx <= rd_idx + cnt_w'(1);
            end
            if (inflight) begin
                buf_q[wr_ptr] <= bus.mem_rd_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr   <= ~rd_ptr;
                pix_cnt  <= pix_cnt + cnt_w'(1);
                head_col <= (head_col == last_col) ? '0 : head_col + col_w'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        base     <= base_addr;
                        rd_idx   <= '0;
                        pix_cnt  <= '0;
                        head_col <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop && (pix_cnt == last_pix)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(inflight && !pop && (count == 2'd2)));
endmodule
